// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory types and widths used by the fetch/load-store RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int WORD_W   = 32;
    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM port bundle for mem_arbiter; master is the arbiter, slave is the CPU/RAM side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                iREN;
    logic [WORD_W-1:0]   iaddr;
    logic                iwait;
    logic [WORD_W-1:0]   iload;

    logic                dREN;
    logic                dWEN;
    logic [WORD_W-1:0]   daddr;
    logic [WORD_W-1:0]   dstore;
    logic                dwait;
    logic [WORD_W-1:0]   dload;

    logic                ramREN;
    logic                ramWEN;
    logic [WORD_W-1:0]   ramaddr;
    logic [WORD_W-1:0]   ramstore;
    logic [WORD_W-1:0]   ramload;
    ramstate_t           ramstate;

    // Consecutive data grants while fetch waits; exported for observation.
    logic [STREAK_W-1:0] dstreak;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, dstreak
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, dstreak
    );

endinterface

// File: rtl/mem_arbiter_streak_counter.sv
// Saturating data-grant streak counter with clear/increment and an at-max flag.
// Latency: count updates on the clock edge after i_inc/i_clr; o_max is combinational on the count.
// Backpressure: none; increments beyond MAX are ignored.
module streak_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_inc,
    input  logic                i_clr,
    output logic [STREAK_W-1:0] o_cnt,
    output logic                o_max
);

    localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX);

    logic [STREAK_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and load/store; data wins until fetch has waited DSTREAK_MAX grants.
// Latency: a request seen in IDLE drives the RAM next cycle; wait drops in the cycle ramstate is ACCESS.
// Backpressure: requesters hold until their wait drops; RAM BUSY/ERROR stretches the grant indefinitely.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    arb_state_t          r_state;
    logic [WORD_W-1:0]   r_last_store;

    logic                w_dreq;
    logic                w_access;
    logic                w_force_fetch;
    logic                w_i_done;
    logic                w_d_done;
    logic                w_streak_inc;
    logic                w_streak_clr;
    logic                w_at_max;
    logic [STREAK_W-1:0] w_dstreak;

    assign w_dreq        = bus.dREN | bus.dWEN;
    assign w_access      = (bus.ramstate == ACCESS);
    assign w_force_fetch = bus.iREN & w_at_max;
    assign w_d_done      = (r_state == DGRANT) & w_dreq & w_access;
    assign w_i_done      = (r_state == IGRANT) & bus.iREN & w_access;

    // A data completion extends the streak only if fetch was left waiting.
    assign w_streak_inc  = w_d_done & bus.iREN;
    assign w_streak_clr  = w_i_done | (w_d_done & ~bus.iREN);

    streak_counter #(
        .MAX (DSTREAK_MAX)
    ) u_streak (
        .clk   (CLK),
        .rst_n (nRST),
        .i_inc (w_streak_inc),
        .i_clr (w_streak_clr),
        .o_cnt (w_dstreak),
        .o_max (w_at_max)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_last_store <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dreq && !w_force_fetch) begin
                        r_state <= DGRANT;
                    end else if (bus.iREN) begin
                        r_state <= IGRANT;
                    end
                end
                DGRANT: begin
                    r_last_store <= bus.dstore;
                    if (w_d_done || !w_dreq) begin
                        r_state <= IDLE;
                    end
                end
                IGRANT: begin
                    if (w_i_done || !bus.iREN) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM request follows the granted requester directly; fetch leaves ramstore at the last data value.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        case (r_state)
            DGRANT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
            end
            IGRANT: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = bus.iaddr;
                bus.ramstore = r_last_store;
                bus.iload    = bus.ramload;
            end
            default: ;
        endcase
    end

    assign bus.iwait   = ~w_i_done;
    assign bus.dwait   = ~w_d_done;
    assign bus.dstreak = w_dstreak;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-ported RAM between the instruction-fetch path (icache side) and the load/store path (dcache side) of the pipelined datapath. It registers one grant at a time, drives the RAM port on behalf of the granted requester, and returns wait/load to each side. Data requests have priority. A streak counter forces an instruction grant after `DSTREAK_MAX` consecutive data grants so fetch cannot starve.

## Interface
- `DSTREAK_MAX`, default 4: consecutive data grants allowed while an instruction request is pending. Range 1..15.
- `CLK  in  1`: clock, rising edge.
- `nRST  in  1`: asynchronous, active-low reset.
- `iREN  in  1`: instruction read request. Held until `iwait` is low.
- `iaddr  in  32`: instruction byte address.
- `iwait  out  1`: high unless `iload` is valid this cycle.
- `iload  out  32`: instruction data. Valid only when `iwait` is low.
- `dREN  in  1`: data read request.
- `dWEN  in  1`: data write request. `dREN` and `dWEN` are never both high.
- `daddr  in  32`: data byte address.
- `dstore  in  32`: write data.
- `dwait  out  1`: high unless the data access completes this cycle.
- `dload  out  32`: read data. Valid only when `dwait` is low.
- `ramREN  out  1`, `ramWEN  out  1`, `ramaddr  out  32`, `ramstore  out  32`: RAM request.
- `ramload  in  32`: RAM read data.
- `ramstate  in  2`: RAM status, type `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, IGRANT, DGRANT. Reset state is IDLE.
- **IDLE.** All `ram*` outputs are 0. Both waits are high.
  - If `dREN|dWEN` is set and the forced-fetch condition does not hold, go to DGRANT.
  - Otherwise, if `iREN` is set, go to IGRANT.
  - Otherwise stay in IDLE.
  - Forced-fetch condition: `iREN` is high and `dstreak == DSTREAK_MAX`.
- **DGRANT.** `ramREN=dREN`, `ramWEN=dWEN`, `ramaddr=daddr`, `ramstore=dstore`.
  - On `ramstate==ACCESS`: `dwait=0`, `dload=ramload`, go to IDLE.
  - If `dREN|dWEN` drops before ACCESS, abandon the access and go to IDLE. No wait is deasserted.
  - On ERROR or BUSY, hold the state and the request.
- **IGRANT.** `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`. `ramstore` holds its last value.
  - On ACCESS: `iwait=0`, `iload=ramload`, go to IDLE.
  - If `iREN` drops before ACCESS, go to IDLE.
- **`dstreak` counter** (4 bits, saturating at `DSTREAK_MAX`):
  - Increments on each data completion while `iREN` is high.
  - Clears on any instruction completion.
  - Clears on a data completion while `iREN` is low.
- `iload` and `dload` are combinational pass-throughs of `ramload`. The non-granted side never sees its wait low.
- Addresses are passed unmodified (byte address). No alignment check.

## Timing
- Reset values: state IDLE, `dstreak` 0, `ramREN`/`ramWEN` 0, `ramaddr`/`ramstore` 0, `iwait`/`dwait` 1, `iload`/`dload` 0 (`ramload` is gated with the grant).
- Reset asserted mid-grant forces IDLE immediately and drops `ram*` asynchronously.
- Latency: a request seen in IDLE at cycle 0 drives RAM from cycle 1. With `ramstate` returning ACCESS after L≥1 cycles, wait goes low at cycle L. The next arbitration is at cycle L+1 (IDLE).
- Minimum issue interval is 2 cycles per transfer.
- Simultaneous `iREN` and `dREN` in IDLE with `dstreak < DSTREAK_MAX`: data wins. At the cap, instruction wins.
- All wait/load outputs are Mealy on `ramstate`. All RAM request outputs are Moore on state plus the requester inputs.

## Structure
- `ramstate_t` (FREE/BUSY/ACCESS/ERROR) lives in the shared CPU types package.
- The FSM state enum `arb_state_t` is local to the module.
- Natural sub-module: `streak_counter`, a saturating counter with clear/increment and a `max` compare.
- The memory arbitration test bench drives a RAM model with programmable latency.

## Test plan
- **Single fetch.** `iREN=1`, `iaddr=0x40`, RAM latency 2 with `ramload=0x2001000A`: `ramREN=1` and `ramaddr=0x40` at cycles 1–2; `iwait=0` and `iload=0x2001000A` at cycle 2; IDLE at cycle 3.
- **Contention.** `iREN=1` and `dWEN=1` (`daddr=0x80`, `dstore=0xDEADBEEF`) in the same IDLE cycle: DGRANT first with `ramWEN=1`; `dwait` falls while `iwait` stays high; IGRANT follows.
- **Starvation guard.** `DSTREAK_MAX=4`, `dREN` held continuously and `iREN` held: exactly 4 data completions, then 1 instruction completion, then data resumes. `dstreak` reads 4 then 0.
- **Withdrawal.** `dREN` in DGRANT drops while `ramstate=BUSY`: the next cycle is IDLE with `ramREN=0`, and `dwait` never goes low.
- **ERROR hold.** `ramstate=ERROR` for 3 cycles, then ACCESS: the grant and `ramaddr` stay stable throughout, and the wait falls only on ACCESS.
- **Reset mid-operation.** `nRST` falls in IGRANT: outputs go to reset values immediately. After release with `iREN=1`, IGRANT is re-entered one cycle later.
